// File: rtl/rf_pkg.sv
// Shared widths, constants and the buffered write-back entry type
// for the register file write path.
package rf_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_lookup_match.sv
// Finds the youngest valid buffered write to a given register index so the
// read stage can forward data that has not reached the register file yet.
module wb_lookup_match
    import rf_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t         entries [DEPTH],
    input  logic [PTR_W-1:0]  head,
    input  logic [ADDR_W-1:0] lk_addr,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    logic [PTR_W-1:0] idx_s;

    // Walk oldest to youngest so the last match (nearest tail) wins.
    always_comb begin
        hit   = 1'b0;
        data  = {DATA_W{1'b0}};
        idx_s = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = head + PTR_W'(i);
            if (entries[idx_s].valid && (entries[idx_s].addr == lk_addr) &&
                (lk_addr != REG_ZERO)) begin
                hit  = 1'b1;
                data = entries[idx_s].data;
            end else begin
                hit  = hit;
                data = data;
            end
        end
    end

endmodule

// File: rtl/regfile_write_buffer.sv
// In-order write-back buffer in front of the register file write port,
// with two lookup ports for forwarding still-pending writes.
module regfile_write_buffer
    import rf_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int ADDR_W = rf_pkg::ADDR_W,
    parameter  int DATA_W = rf_pkg::DATA_W,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              rf_wready,
    input  logic [ADDR_W-1:0] lk_addr1,
    input  logic [ADDR_W-1:0] lk_addr2,
    output logic              lk_hit1,
    output logic              lk_hit2,
    output logic [DATA_W-1:0] lk_data1,
    output logic [DATA_W-1:0] lk_data2,
    output logic [CNT_W-1:0]  count
);

    wb_entry_t        mem_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic             accept_s;
    logic             enq_s;
    logic             deq_s;

    assign wb_ready = !reset && (count_r < CNT_W'(DEPTH));
    assign accept_s = wb_valid && wb_ready;
    // Writes to the zero register complete the handshake but are never stored.
    assign enq_s    = accept_s && (wb_addr != REG_ZERO);
    assign deq_s    = (count_r != {CNT_W{1'b0}}) && rf_wready;
    assign count    = count_r;

    // Pointer, occupancy and entry storage update.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {$bits(wb_entry_t){1'b0}};
            end
        end else begin
            if (enq_s) begin
                mem_r[tail_r] <= '{valid: 1'b1, addr: wb_addr, data: wb_data};
                tail_r        <= tail_r + PTR_W'(1);
            end
            if (deq_s) begin
                mem_r[head_r].valid <= 1'b0;
                head_r              <= head_r + PTR_W'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Present the head entry to the register file; zeros when empty.
    always_comb begin
        rf_we = (count_r != {CNT_W{1'b0}});
        if (rf_we) begin
            rf_waddr = mem_r[head_r].addr;
            rf_wdata = mem_r[head_r].data;
        end else begin
            rf_waddr = {ADDR_W{1'b0}};
            rf_wdata = {DATA_W{1'b0}};
        end
    end

    wb_lookup_match #(.DEPTH(DEPTH)) u_lookup1 (
        .entries (mem_r),
        .head    (head_r),
        .lk_addr (lk_addr1),
        .hit     (lk_hit1),
        .data    (lk_data1)
    );

    wb_lookup_match #(.DEPTH(DEPTH)) u_lookup2 (
        .entries (mem_r),
        .head    (head_r),
        .lk_addr (lk_addr2),
        .hit     (lk_hit2),
        .data    (lk_data2)
    );

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Bench for regfile_write_buffer: directed scenarios plus randomized traffic
// checked against a queue-based model of the pending writes.
module tb_regfile_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wb_valid = 1'b0;
    logic          wb_ready;
    logic [AW-1:0] wb_addr = 5'd0;
    logic [DW-1:0] wb_data = 32'd0;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          rf_wready = 1'b0;
    logic [AW-1:0] lk_addr1 = 5'd0;
    logic [AW-1:0] lk_addr2 = 5'd0;
    logic          lk_hit1, lk_hit2;
    logic [DW-1:0] lk_data1, lk_data2;
    logic [CW-1:0] count;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t q[$];        // pending writes, oldest first
    ent_t commits[$];  // writes observed leaving toward the register file
    int   checks = 0;
    int   errors = 0;

    regfile_write_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .rf_wready(rf_wready), .lk_addr1(lk_addr1),
        .lk_addr2(lk_addr2), .lk_hit1(lk_hit1), .lk_hit2(lk_hit2),
        .lk_data1(lk_data1), .lk_data2(lk_data2), .count(count)
    );

    always #5 clk = ~clk;

    function automatic void ref_lookup(input logic [AW-1:0] a, output logic hit,
                                       output logic [DW-1:0] d);
        hit = 1'b0;
        d   = 32'd0;
        if (a != 5'd0) begin
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].a == a) begin
                    hit = 1'b1;
                    d   = q[i].d;
                end
            end
        end
    endfunction

    // One clock: log any commit seen at negedge, then apply the edge to the model.
    task automatic tick();
        bit   acc;
        ent_t e;
        @(negedge clk);
        if (rf_we && rf_wready && !reset) begin
            e.a = rf_waddr;
            e.d = rf_wdata;
            commits.push_back(e);
        end
        acc = !reset && wb_valid && (q.size() < DEPTH);
        @(posedge clk);
        if (reset) begin
            q.delete();
        end else begin
            if (q.size() != 0 && rf_wready) void'(q.pop_front());
            if (acc && wb_addr != 5'd0) begin
                e.a = wb_addr;
                e.d = wb_data;
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h5555_5555;
        #1;
        checks++;
        if (wb_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low got %0b want 0", wb_ready); end
        tick();
        tick();
        reset = 1'b0; wb_valid = 1'b0; lk_addr1 = 5'd5; lk_addr2 = 5'd3;
        #1;
        checks++;
        if ({wb_ready, rf_we, rf_waddr, rf_wdata, count, lk_hit1, lk_hit2, lk_data1, lk_data2} !==
            {1'b1, 1'b0, 5'd0, 32'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL post_reset got ready=%0b we=%0b waddr=%0d wdata=%h count=%0d hit=%0b%0b d1=%h d2=%h want 1 0 0 0 0 00 0 0",
                     wb_ready, rf_we, rf_waddr, rf_wdata, count, lk_hit1, lk_hit2, lk_data1, lk_data2);
        end
    endtask

    task automatic test_back_to_back();
        rf_wready = 1'b1; commits.delete();
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h3333_3333;
        #1;
        checks++;
        if (rf_we !== 1'b0) begin errors++; $display("FAIL b2b_no_bypass got we=%0b want 0", rf_we); end
        tick();
        wb_addr = 5'd7; wb_data = 32'h7777_7777;
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h3333_3333}) begin
            errors++; $display("FAIL b2b_first got we=%0b %0d %h want 1 3 33333333", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        wb_valid = 1'b0;
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h7777_7777}) begin
            errors++; $display("FAIL b2b_second got we=%0b %0d %h want 1 7 77777777", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        #1;
        checks++;
        if ({rf_we, count} !== {1'b0, 3'd0} || commits.size() != 2) begin
            errors++; $display("FAIL b2b_empty got we=%0b count=%0d commits=%0d want 0 0 2", rf_we, count, commits.size());
        end
    endtask

    task automatic test_backpressure();
        rf_wready = 1'b0; commits.delete();
        for (int k = 1; k <= 5; k++) begin
            wb_valid = 1'b1; wb_addr = AW'(k); wb_data = 32'h1000_0000 + DW'(k);
            #1;
            checks++;
            if (k == 5) begin
                if ({wb_ready, count} !== {1'b0, 3'd4}) begin
                    errors++; $display("FAIL bp_full got ready=%0b count=%0d want 0 4", wb_ready, count);
                end
            end else if (wb_ready !== 1'b1) begin
                errors++; $display("FAIL bp_accept_%0d got ready=%0b want 1", k, wb_ready);
            end
            if (k < 5) tick();
        end
        rf_wready = 1'b1;
        #1;
        checks++;
        if (wb_ready !== 1'b0) begin errors++; $display("FAIL bp_no_widen got ready=%0b want 0", wb_ready); end
        tick();
        checks++;
        if (wb_ready !== 1'b1) begin errors++; $display("FAIL bp_reopen got ready=%0b want 1", wb_ready); end
        tick();
        wb_valid = 1'b0;
        for (int i = 0; i < 10 && count != 3'd0; i++) tick();
        checks++;
        if (commits.size() != 5) begin
            errors++; $display("FAIL bp_commit_count got %0d want 5", commits.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (commits[k].a !== AW'(k + 1) || commits[k].d !== 32'h1000_0000 + DW'(k + 1)) begin
                    errors++; $display("FAIL bp_order_%0d got %0d/%h want %0d/%h", k, commits[k].a, commits[k].d,
                                       k + 1, 32'h1000_0000 + DW'(k + 1));
                end
            end
        end
    endtask

    task automatic test_lookup_youngest();
        rf_wready = 1'b0;
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'hAAAA_AAAA;
        tick();
        wb_data = 32'hBBBB_BBBB;
        tick();
        wb_valid = 1'b0; lk_addr1 = 5'd9; lk_addr2 = 5'd0;
        #1;
        checks++;
        if ({lk_hit1, lk_data1, lk_hit2, lk_data2} !== {1'b1, 32'hBBBB_BBBB, 1'b0, 32'd0}) begin
            errors++; $display("FAIL lk_youngest got %0b %h %0b %h want 1 bbbbbbbb 0 0", lk_hit1, lk_data1, lk_hit2, lk_data2);
        end
        rf_wready = 1'b1;
        tick();
        // Second entry is at the head and draining this cycle: still a hit.
        checks++;
        if ({lk_hit1, lk_data1, rf_we} !== {1'b1, 32'hBBBB_BBBB, 1'b1}) begin
            errors++; $display("FAIL lk_head_drain got %0b %h we=%0b want 1 bbbbbbbb 1", lk_hit1, lk_data1, rf_we);
        end
        tick();
        checks++;
        if ({lk_hit1, lk_data1, count} !== {1'b0, 32'd0, 3'd0}) begin
            errors++; $display("FAIL lk_after_drain got %0b %h count=%0d want 0 0 0", lk_hit1, lk_data1, count);
        end
    endtask

    task automatic test_zero_addr();
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF; lk_addr1 = 5'd0;
        #1;
        checks++;
        if (wb_ready !== 1'b1) begin errors++; $display("FAIL zero_handshake got ready=%0b want 1", wb_ready); end
        tick();
        wb_valid = 1'b0;
        #1;
        checks++;
        if ({count, rf_we} !== {3'd0, 1'b0}) begin
            errors++; $display("FAIL zero_not_queued got count=%0d we=%0b want 0 0", count, rf_we);
        end
    endtask

    task automatic test_reset_mid();
        rf_wready = 1'b0; commits.delete();
        for (int k = 0; k < 3; k++) begin
            wb_valid = 1'b1; wb_addr = AW'(10 + k); wb_data = 32'hC000_0000 + DW'(k);
            tick();
        end
        reset = 1'b1; wb_addr = 5'd13;
        #1;
        checks++;
        if (wb_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got %0b want 0", wb_ready); end
        tick();
        reset = 1'b0; wb_valid = 1'b0; rf_wready = 1'b1;
        #1;
        checks++;
        if ({count, rf_we} !== {3'd0, 1'b0}) begin
            errors++; $display("FAIL mid_reset_state got count=%0d we=%0b want 0 0", count, rf_we);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (commits.size() != 0) begin
            errors++; $display("FAIL mid_reset_leak got %0d commits want 0", commits.size());
        end
    endtask

    task automatic test_random();
        logic [41:0]   exp_main;
        logic          eh1, eh2;
        logic [DW-1:0] ed1, ed2;
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 49) == 0);
            wb_valid  = $urandom_range(0, 2) != 0;
            wb_addr   = AW'($urandom_range(0, 7));
            wb_data   = $urandom;
            rf_wready = $urandom_range(0, 9) < 6;
            lk_addr1  = AW'($urandom_range(0, 7));
            lk_addr2  = AW'($urandom_range(0, 7));
            #1;
            exp_main = {!reset && (q.size() < DEPTH), q.size() != 0,
                        (q.size() != 0) ? q[0].a : 5'd0, (q.size() != 0) ? q[0].d : 32'd0,
                        CW'(q.size())};
            ref_lookup(lk_addr1, eh1, ed1);
            ref_lookup(lk_addr2, eh2, ed2);
            checks++;
            if ({wb_ready, rf_we, rf_waddr, rf_wdata, count} !== exp_main) begin
                errors++; $display("FAIL rand_main cycle %0d got %h want %h", n,
                                   {wb_ready, rf_we, rf_waddr, rf_wdata, count}, exp_main);
            end
            checks++;
            if ({lk_hit1, lk_data1, lk_hit2, lk_data2} !== {eh1, ed1, eh2, ed2}) begin
                errors++; $display("FAIL rand_lookup cycle %0d got %0b %h %0b %h want %0b %h %0b %h", n,
                                   lk_hit1, lk_data1, lk_hit2, lk_data2, eh1, ed1, eh2, ed2);
            end
            tick();
        end
        reset = 1'b0; wb_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_lookup_youngest();
        test_zero_addr();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_buffer.md
Name: regfile_write_buffer

Overview:
- Write-side companion to the register file's clocked read ports.
- Accepts register write-back requests from the execute/memory stage over a valid/ready handshake and queues them in a small in-order buffer.
- Drains one write per cycle into the register file write port.
- Exposes a two-port lookup so the read stage can detect and forward values still pending in the buffer.

Parameters:
- DEPTH, 4, number of buffered write entries (power of two, ≥2)
- ADDR_W, 5, register index width (32 registers, index 0 hard-wired zero)
- DATA_W, 32, register data width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- wb_valid  in  1  write request present
- wb_ready  out  1  buffer can accept a request
- wb_addr  in  ADDR_W  destination register index
- wb_data  in  DATA_W  write data
- rf_we  out  1  head entry presented to register file
- rf_waddr  out  ADDR_W  head entry index
- rf_wdata  out  DATA_W  head entry data
- rf_wready  in  1  register file accepts head this cycle
- lk_addr1  in  ADDR_W  lookup index, read port 1
- lk_addr2  in  ADDR_W  lookup index, read port 2
- lk_hit1  out  1  pending write to lk_addr1 exists
- lk_hit2  out  1  pending write to lk_addr2 exists
- lk_data1  out  DATA_W  youngest pending data for lk_addr1
- lk_data2  out  DATA_W  youngest pending data for lk_addr2
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Single clock `clk`. Reset `reset` is synchronous and active-high; it is sampled only on the rising edge of `clk`.
- Reset (at the edge with reset=1):
  - Head/tail pointers and count are cleared; all entry valid bits are cleared; storage contents are don't-care.
  - Any request presented that cycle is dropped, and nothing drains that cycle.
  - wb_ready=0 while reset is high.
- Reset mid-operation: discards all pending writes. They are never presented to the register file.
- Post-reset outputs: wb_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, lk_hit*=0, lk_data*=0, count=0.
- Accept: a request is taken at the edge where wb_valid=1 and wb_ready=1.
- wb_ready = !reset && (count < DEPTH). It is not widened by a same-cycle drain: a full buffer refuses input even if rf_wready=1.
- A request with wb_addr=0 is accepted (handshake completes) but not enqueued. count is unchanged.
- Enqueue: the entry is written at tail, tail increments modulo DEPTH, and count increments.
- Drain:
  - rf_we = (count != 0).
  - rf_waddr/rf_wdata are driven from the head entry's registered storage, and are 0 when empty.
  - At an edge with rf_we=1 and rf_wready=1, head increments modulo DEPTH and count decrements.
- Latency: a request accepted at edge N appears on rf_* no earlier than the cycle after edge N. Order is strictly FIFO.
- Simultaneous enqueue and drain: count is unchanged, and both pointers advance.
- Empty + incoming request: no bypass to rf_*. The request is visible only from the next cycle.
- Wrap-around: pointers wrap at DEPTH with no bubble.
- Lookup:
  - Purely combinational over valid buffered entries (this cycle's incoming request is excluded).
  - lk_hitN=1 iff lk_addrN != 0 and some valid entry matches.
  - lk_dataN is the youngest matching entry (nearest to tail); it is 0 when there is no hit.
  - The head entry being drained this cycle still counts as a hit this cycle.
- rf_wready=0 stalls the head indefinitely; the buffer fills and then backpressures.

Decomposition:
- Shared package `rf_pkg`:
  - ADDR_W and DATA_W constants
  - REG_ZERO index constant
  - `wb_entry_t` typedef with fields {valid, addr, data}
- One sub-module, `wb_lookup_match`:
  - Inputs: entry array, head pointer, lookup address.
  - Outputs: hit and youngest-match data, using a priority scan from tail-1 back to head.
  - Instantiated twice, once per lookup port.

Test Plan:
1. Reset then idle → wb_ready=1, rf_we=0, count=0, lk_hit1=lk_hit2=0.
2. With rf_wready=1: send (3, 0x33333333), then (7, 0x77777777) on consecutive cycles → rf_we pulses on consecutive cycles with addr 3 then 7 and matching data; count returns to 0.
3. Hold rf_wready=0 and send 5 requests to addrs 1..5 → first 4 accepted; wb_ready=0 with count=4 before the 5th; raise rf_wready → commit order 1,2,3,4, then the 5th is accepted.
4. Buffer (9, 0xAAAAAAAA) then (9, 0xBBBBBBBB) with rf_wready=0; set lk_addr1=9, lk_addr2=0 → lk_hit1=1, lk_data1=0xBBBBBBBB; lk_hit2=0.
5. Send (0, 0xDEADBEEF) → handshake completes, count stays 0, rf_we stays 0.
6. Fill 3 entries, then assert reset for one cycle while wb_valid=1 → count=0, rf_we=0, and none of the pre-reset writes ever appear on rf_*.
